// File: rtl/lfsr_error_injector.sv
// ----------------------------------------------------------------------------
// lfsr_error_injector
//
// This stage sits between the LFSR generator and the LFSR checker. It XORs an
// error mask into selected valid words. The words can be chosen in three ways:
// single-shot (on a trigger edge), periodic, or periodic burst. It also keeps
// a saturating count of corrupted words, so that checker lock and unlock
// events can be matched against known injections.
//
// Optional build macro:
//   ERR_INJ_WALK_EN - Defined: the mask is held in a register that rotates
//                     left by one bit after every injected beat.
//                     Undefined: i_err_mask is applied directly.
//
// Ports:
//   clk          system clock
//   i_rst_n      asynchronous active-low reset
//   i_soft_reset synchronous clear of all state and outputs
//   i_valid      input word valid
//   i_data       input LFSR word
//   i_mode       00 off, 01 single-shot, 10 periodic, 11 periodic burst
//   i_trigger    single-shot request level (rising edge detected here)
//   i_period     valid beats per injection cycle (0 behaves as 1)
//   i_burst_len  corrupted beats per burst in mode 11 (0 behaves as 1)
//   i_err_mask   XOR mask for corrupted words
//   o_valid      registered i_valid
//   o_data       registered, possibly corrupted word (held while !i_valid)
//   o_err_flag   high while o_data carries a corrupted word
//   o_err_count  saturating count of corrupted words
// ----------------------------------------------------------------------------
module lfsr_error_injector #(
    parameter int NB_DATA   = 8,
    parameter int NB_PERIOD = 16,
    parameter int NB_BURST  = 4,
    parameter int NB_COUNT  = 16
) (
    input  logic                 clk,
    input  logic                 i_rst_n,
    input  logic                 i_soft_reset,
    input  logic                 i_valid,
    input  logic [NB_DATA-1:0]   i_data,
    input  logic [1:0]           i_mode,
    input  logic                 i_trigger,
    input  logic [NB_PERIOD-1:0] i_period,
    input  logic [NB_BURST-1:0]  i_burst_len,
    input  logic [NB_DATA-1:0]   i_err_mask,
    output logic                 o_valid,
    output logic [NB_DATA-1:0]   o_data,
    output logic                 o_err_flag,
    output logic [NB_COUNT-1:0]  o_err_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DONE,
        ST_COUNT,
        ST_BURST
    } state_t;

    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_BURST  = 2'b11;

    state_t               state_q, state_d;
    logic [1:0]           mode_q;
    logic                 trig_q;
    logic [NB_PERIOD-1:0] period_cnt_q, period_cnt_d;
    logic [NB_BURST-1:0]  burst_cnt_q, burst_cnt_d;

    logic                 valid_q;
    logic [NB_DATA-1:0]   data_q;
    logic                 err_flag_q;
    logic [NB_COUNT-1:0]  err_count_q;

    logic                 inject;
    logic                 mode_change;
    logic                 trig_rise;
    logic [NB_DATA-1:0]   mask;
    logic [NB_PERIOD-1:0] period_last;
    logic [NB_BURST-1:0]  burst_last;

    assign mode_change = (i_mode != mode_q);
    assign trig_rise   = i_trigger & ~trig_q;

    // Last counter value of a cycle. A programmed 0 behaves like 1.
    assign period_last = (i_period == '0) ? '0 : i_period - NB_PERIOD'(1);
    assign burst_last  = (i_burst_len == '0) ? '0 : i_burst_len - NB_BURST'(1);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        state_d      = state_q;
        period_cnt_d = period_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        inject       = 1'b0;

        if (mode_change) begin
            // The beat in this cycle passes clean. The new mode starts next cycle.
            state_d      = ST_IDLE;
            period_cnt_d = '0;
            burst_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_COUNT: begin
                    if (mode_q[1]) begin
                        // Periodic modes: IDLE enters COUNT with the counter
                        // at 0 and judges this beat as the first one counted.
                        state_d = ST_COUNT;
                        if (i_valid) begin
                            if (period_cnt_q == period_last) begin
                                inject       = 1'b1;
                                period_cnt_d = '0;
                                if (mode_q == MODE_BURST && burst_last != '0) begin
                                    state_d     = ST_BURST;
                                    burst_cnt_d = NB_BURST'(1);
                                end
                            end else begin
                                // A period lowered below the count wraps at overflow.
                                period_cnt_d = period_cnt_q + NB_PERIOD'(1);
                            end
                        end
                    end else if (state_q == ST_COUNT) begin
                        state_d = ST_IDLE;
                    end else if (mode_q == MODE_SINGLE && trig_rise) begin
                        // Arming does not corrupt the beat in this cycle.
                        state_d = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (i_valid) begin
                        inject  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A held trigger gives no second shot. It must drop first.
                    if (!i_trigger) state_d = ST_IDLE;
                end
                ST_BURST: begin
                    if (i_valid) begin
                        inject = 1'b1;
                        if (burst_cnt_q == burst_last) begin
                            state_d      = ST_COUNT;
                            burst_cnt_d  = '0;
                            period_cnt_d = '0;
                        end else begin
                            burst_cnt_d = burst_cnt_q + NB_BURST'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef ERR_INJ_WALK_EN
    // walk_loaded_q = 0 means the mask follows i_err_mask. This is how the
    // register gets reloaded on reset, soft reset, mode change and IDLE entry.
    logic [NB_DATA-1:0] walk_mask_q;
    logic               walk_loaded_q;

    assign mask = walk_loaded_q ? walk_mask_q : i_err_mask;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            walk_mask_q   <= '0;
            walk_loaded_q <= 1'b0;
        end else if (i_soft_reset || state_d == ST_IDLE) begin
            walk_loaded_q <= 1'b0;
        end else if (inject) begin
            walk_mask_q   <= {mask[NB_DATA-2:0], mask[NB_DATA-1]};
            walk_loaded_q <= 1'b1;
        end
    end
`else
    assign mask = i_err_mask;
`endif

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    // NOTE: state uses non-blocking assignments so that every register samples
    // pre-edge values. The async reset clears all of them to known values.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            mode_q       <= '0;
            trig_q       <= 1'b0;
            period_cnt_q <= '0;
            burst_cnt_q  <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            err_flag_q   <= 1'b0;
            err_count_q  <= '0;
        end else if (i_soft_reset) begin
            state_q      <= ST_IDLE;
            mode_q       <= '0;
            trig_q       <= 1'b0;
            period_cnt_q <= '0;
            burst_cnt_q  <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            err_flag_q   <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            mode_q       <= i_mode;
            trig_q       <= i_trigger;
            period_cnt_q <= period_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            valid_q      <= i_valid;
            if (i_valid) data_q <= i_data ^ (inject ? mask : '0);
            err_flag_q   <= inject;
            if (inject && err_count_q != '1) err_count_q <= err_count_q + NB_COUNT'(1);
        end
    end

    assign o_valid     = valid_q;
    assign o_data      = data_q;
    assign o_err_flag  = err_flag_q;
    assign o_err_count = err_count_q;

endmodule

// File: doc/lfsr_error_injector.md
Name: lfsr_error_injector

Overview:
Programmable error-injection stage between the LFSR generator output and the LFSR checker input, replacing the fixed bit-0 corrupt mux. It XORs a mask into selected valid words in single-shot, periodic or periodic-burst patterns. It also counts injected words so the checker's lock/unlock behaviour can be correlated with known error events on VIO/ILA.

Parameters:
NB_DATA, 8, data word width (matches LFSR width)
NB_PERIOD, 16, width of injection period register/counter
NB_BURST, 4, width of burst-length register/counter
NB_COUNT, 16, width of injected-word counter

Ports:
clk  in  1  system clock (100 MHz)
i_rst_n  in  1  reset, asynchronous, active-low
i_soft_reset  in  1  synchronous clear: FSM to IDLE, counters to 0, outputs to reset values
i_valid  in  1  input word valid
i_data  in  NB_DATA  input LFSR word
i_mode  in  2  00 off, 01 single-shot, 10 periodic, 11 periodic burst
i_trigger  in  1  single-shot request, level from VIO; edge-detected internally
i_period  in  NB_PERIOD  valid beats per injection cycle; 0 treated as 1
i_burst_len  in  NB_BURST  consecutive corrupted beats in mode 11; 0 treated as 1
i_err_mask  in  NB_DATA  XOR mask applied to corrupted words
o_valid  out  1  registered i_valid
o_data  out  NB_DATA  registered, possibly corrupted word
o_err_flag  out  1  high for the cycle in which o_data carries a corrupted word
o_err_count  out  NB_COUNT  number of corrupted words; saturating

Behaviour:
- Reset (async i_rst_n low, or i_soft_reset high at clk edge): o_valid=0, o_data=0, o_err_flag=0, o_err_count=0, FSM=IDLE, period counter=0, burst counter=0, trigger edge register=0, stored mode=0.
- Latency is 1 cycle. o_valid <= i_valid every cycle. o_data <= i_data ^ (inject ? mask : 0) only when i_valid=1. When i_valid=0, o_data holds its value.
- o_err_flag <= i_valid & inject. Injection decisions advance only on valid beats.
- o_err_count increments on every injected beat, saturates at all-ones, and counts even when the mask is 0.
- Mode change: i_mode is registered. If i_mode != stored mode, the FSM goes to IDLE and both counters clear. The beat in that cycle passes uncorrupted. The new mode takes effect from the next cycle.
- FSM states:
  - IDLE: mode 00 passes data through. Mode 01 goes to ARMED on a trigger rising edge (i_trigger=1, previous sample 0). Mode 10 or 11 goes to COUNT with period counter=0.
  - ARMED: the next valid beat is corrupted, then the FSM goes to DONE. With no valid beat, it waits in ARMED indefinitely.
  - DONE: returns to IDLE when i_trigger=0. A held trigger never gives a second injection.
  - COUNT: on each valid beat, if counter == max(i_period,1)-1 the beat is corrupted and the counter clears.
    - Mode 10 stays in COUNT.
    - Mode 11 goes to BURST with burst counter=1 if max(i_burst_len,1)>1, otherwise stays in COUNT.
    - If the compare fails, the counter increments.
  - BURST: each valid beat is corrupted and the burst counter increments. When the counter reaches max(i_burst_len,1)-1, the FSM returns to COUNT with the period counter at 0. The period count restarts after the burst ends.
- i_period and i_burst_len are sampled live. A change mid-count takes effect at the next compare. A period lowered below the current count wraps the counter to 0 at NB_PERIOD overflow. Only lowering the period at run time causes this wrap.
- Simultaneous events:
  - Reset dominates soft reset, which dominates mode change, which dominates trigger/injection.
  - A trigger edge in the same cycle as a valid beat in IDLE only arms; it does not corrupt that beat.
- Mode 00 never corrupts, and o_err_flag=0.

Optional Feature:
ERR_INJ_WALK_EN
- Defined: an internal NB_DATA mask register loads i_err_mask on reset, soft reset, mode change and on entry to IDLE. It rotates left by 1 after each injected beat, so successive errors walk across bit positions. The mask applied to data is this register.
- Not defined: i_err_mask is applied directly and combinationally every injected beat. No mask register exists.

Test Plan:
- Mode 00, i_valid=1 continuous, i_data=0x3C: o_data=0x3C one cycle later, o_err_flag never 1, o_err_count=0.
- Mode 01, mask 0x01, data 0xA5, trigger held high 50 cycles: exactly one o_data=0xA4 with o_err_flag=1, count=1. Drop and raise trigger again: count=2.
- Mode 10, period 4, mask 0x80, continuous valid: corrupted on valid beats 4, 8, 12, and so on (1-based). After 40 beats o_err_count=10.
- Mode 11, period 3, burst 2, mask 0xFF: pattern repeats every 4 beats as 2 clean beats, then 2 inverted beats (beats 3-4, 7-8, ...). i_valid toggling every other cycle stretches the pattern but preserves beat counts.
- Mid-burst switch mode 11 to 10: that beat is clean, the FSM restarts counting, and the next injection lands at beat i_period after the switch. Assert i_rst_n=0 asynchronously mid-burst: all outputs are 0 immediately.
- Saturation: force NB_COUNT=4, mode 10 with period 0 (every beat), 20 beats: o_err_count sticks at 0xF.
- With ERR_INJ_WALK_EN, mask 0x01, period 1: injected masks are 0x01, 0x02, 0x04 … 0x80, 0x01.
